// File: rtl/xbar_pkg.sv
// xbar_pkg -- shared types and helpers for the crossbar scheduler.
//   sel_t       : select code container, wide enough for the largest
//                 supported port count (16 ports -> 5 bits).
//   SEL_NONE    : select code meaning "no input granted".
//   dest_field(): masks the destination field out of the low bits of a
//                 FIFO head word.
package xbar_pkg;

   localparam int MAX_PORTS  = 16;
   localparam int MAX_SEL_W  = 5;
   localparam int MAX_DEST_W = 4;

   typedef logic [MAX_SEL_W-1:0] sel_t;

   localparam sel_t SEL_NONE = '0;

   // Keep only the dest_w low bits; callers zero-extend their slice first.
   function automatic logic [MAX_DEST_W-1:0] dest_field(
      input logic [MAX_DEST_W-1:0] lsbs,
      input int                    dest_w
   );
      logic [MAX_DEST_W-1:0] mask;
      mask = (MAX_DEST_W'(1) << dest_w) - MAX_DEST_W'(1);
      return lsbs & mask;
   endfunction

endpackage

// File: rtl/xbar_sched_rr_arbiter.sv
// rr_arbiter -- per-output arbiter of the crossbar scheduler.
//   req     in  N      requesting inputs
//   ready   in  1      output can accept; no grant when low
//   ptr     in  IDX_W  last granted input (search starts at ptr+1)
//   gnt     out N      one-hot grant
//   gnt_idx out IDX_W  index of the granted input
// Config macro SCHED_RR_EN: defined = round-robin from ptr+1,
// undefined = fixed priority (lowest index wins, ptr ignored).
module rr_arbiter #(
   parameter int N     = 4,
   parameter int IDX_W = 2
) (
   input  logic [N-1:0]     req,
   input  logic             ready,
   input  logic [IDX_W-1:0] ptr,
   output logic [N-1:0]     gnt,
   output logic [IDX_W-1:0] gnt_idx
);

   logic found;

`ifdef SCHED_RR_EN
   logic [IDX_W-1:0] idx;

   // Walk N positions starting just after the last winner; wraps mod N.
   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      found   = 1'b0;
      idx     = '0;
      for (int k = 1; k <= N; k++) begin
         idx = IDX_W'((int'(ptr) + k) % N);
         if (ready && !found && req[idx]) begin
            found      = 1'b1;
            gnt[idx]   = 1'b1;
            gnt_idx    = idx;
         end
      end
   end
`else
   logic unused_ptr;
   assign unused_ptr = ^ptr;

   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      found   = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (ready && !found && req[IDX_W'(i)]) begin
            found             = 1'b1;
            gnt[IDX_W'(i)]    = 1'b1;
            gnt_idx           = IDX_W'(i);
         end
      end
   end
`endif

endmodule

// File: rtl/xbar_sched.sv
// xbar_sched -- crossbar scheduler. Once per SCHED_PERIOD-cycle window it
// looks at every input FIFO head, arbitrates per output and issues one-cycle
// FIFO pops plus crossbar select/enable pulses.
//   clk, rst_n        clock / async active-low reset
//   data_in[i]        head word of input FIFO i (dest in low DEST_W bits)
//   fifo_empty[i]     input FIFO i empty
//   out_ready[j]      output j can take a packet this window
//   sel[j]            0 = none, i+1 = input i routed to output j
//   en[j]             output j granted
//   rdreq[i]          pop input FIFO i (granted or dropped)
//   drop[i]           input i head discarded (destination out of range)
// Config macro SCHED_RR_EN: defined = round-robin per output,
// undefined = fixed priority and no pointer registers.
module xbar_sched
   import xbar_pkg::*;
#(
   parameter  int NPORTS       = 4,
   parameter  int DATA_W       = 32,
   parameter  int SCHED_PERIOD = 3,
   localparam int SEL_W        = $clog2(NPORTS + 1),
   localparam int DEST_W       = (NPORTS > 2) ? $clog2(NPORTS) : 1
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic [NPORTS-1:0][DATA_W-1:0]  data_in,
   input  logic [NPORTS-1:0]              fifo_empty,
   input  logic [NPORTS-1:0]              out_ready,
   output logic [NPORTS-1:0][SEL_W-1:0]   sel,
   output logic [NPORTS-1:0]              en,
   output logic [NPORTS-1:0]              rdreq,
   output logic [NPORTS-1:0]              drop
);

   localparam int PH_W = (SCHED_PERIOD > 1) ? $clog2(SCHED_PERIOD) : 1;

   // ---------------- phase counter ----------------
   logic [PH_W-1:0] phase_q, phase_d;
   logic            decide;

   assign decide = (phase_q == PH_W'(SCHED_PERIOD - 1));

   always_comb begin
      phase_d = decide ? '0 : phase_q + PH_W'(1);
   end

   // ---------------- head decode ----------------
   logic [NPORTS-1:0]                  valid, bad;
   logic [NPORTS-1:0][MAX_DEST_W-1:0]  dest;
   logic [NPORTS-1:0][NPORTS-1:0]      req_mat;   // [output][input]
   logic [NPORTS-1:0][NPORTS-1:0]      gnt_mat;   // [output][input]
   logic [NPORTS-1:0][DEST_W-1:0]      gnt_idx;
   logic [NPORTS-1:0][DEST_W-1:0]      ptr;

   always_comb begin
      valid   = '0;
      bad     = '0;
      dest    = '0;
      req_mat = '0;
      for (int i = 0; i < NPORTS; i++) begin
         dest[i]  = dest_field(MAX_DEST_W'(data_in[i][DEST_W-1:0]), DEST_W);
         // An all-zero head is an idle word, not a packet.
         valid[i] = !fifo_empty[i] && (data_in[i] != '0);
         bad[i]   = valid[i] && (32'(dest[i]) >= 32'(NPORTS));
      end
      for (int j = 0; j < NPORTS; j++) begin
         for (int i = 0; i < NPORTS; i++) begin
            req_mat[j][i] = valid[i] && !bad[i] && (dest[i] == MAX_DEST_W'(j));
         end
      end
   end

   // ---------------- per-output arbiters ----------------
   for (genvar j = 0; j < NPORTS; j++) begin : g_arb
      rr_arbiter #(
         .N     (NPORTS),
         .IDX_W (DEST_W)
      ) u_arb (
         .req     (req_mat[j]),
         .ready   (out_ready[j]),
         .ptr     (ptr[j]),
         .gnt     (gnt_mat[j]),
         .gnt_idx (gnt_idx[j])
      );
   end

   // ---------------- round-robin pointers ----------------
`ifdef SCHED_RR_EN
   localparam logic [DEST_W-1:0] PTR_RST = DEST_W'(NPORTS - 1);

   logic [NPORTS-1:0][DEST_W-1:0] ptr_q, ptr_d;

   // Pointer only moves on an actual grant; a blocked output keeps its turn.
   always_comb begin
      ptr_d = ptr_q;
      if (decide) begin
         for (int j = 0; j < NPORTS; j++) begin
            if (|gnt_mat[j]) ptr_d[j] = gnt_idx[j];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ptr_q <= {NPORTS{PTR_RST}};
      else        ptr_q <= ptr_d;
   end

   assign ptr = ptr_q;
`else
   assign ptr = '0;
`endif

   // ---------------- registered outputs ----------------
   logic [NPORTS-1:0][SEL_W-1:0] sel_q, sel_d;
   logic [NPORTS-1:0]            en_q, en_d;
   logic [NPORTS-1:0]            rdreq_q, rdreq_d;
   logic [NPORTS-1:0]            drop_q, drop_d;
   sel_t                         sel_code;

   // Everything is zero outside the decision edge, so each output is a
   // single-cycle pulse.
   always_comb begin
      sel_d    = '0;
      en_d     = '0;
      rdreq_d  = '0;
      drop_d   = '0;
      sel_code = SEL_NONE;
      if (decide) begin
         for (int j = 0; j < NPORTS; j++) begin
            en_d[j] = |gnt_mat[j];
            if (en_d[j]) begin
               sel_code = sel_t'(gnt_idx[j]) + sel_t'(1);
               sel_d[j] = SEL_W'(sel_code);
            end
         end
         for (int i = 0; i < NPORTS; i++) begin
            rdreq_d[i] = bad[i];
            for (int j = 0; j < NPORTS; j++) begin
               rdreq_d[i] = rdreq_d[i] | gnt_mat[j][i];
            end
         end
         drop_d = bad;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         phase_q <= '0;
         sel_q   <= '0;
         en_q    <= '0;
         rdreq_q <= '0;
         drop_q  <= '0;
      end else begin
         phase_q <= phase_d;
         sel_q   <= sel_d;
         en_q    <= en_d;
         rdreq_q <= rdreq_d;
         drop_q  <= drop_d;
      end
   end

   assign sel   = sel_q;
   assign en    = en_q;
   assign rdreq = rdreq_q;
   assign drop  = drop_q;

endmodule

// File: tb/tb_xbar_sched.sv
// tb_xbar_sched -- directed bench for xbar_sched: a 4-port and a 3-port
// instance, both with a 3-cycle window, sharing clock and reset.
module tb_xbar_sched;

   localparam int P = 3;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   // 4-port instance
   logic [3:0][31:0] d4_data;
   logic [3:0]       d4_empty, d4_ready;
   logic [3:0][2:0]  d4_sel;
   logic [3:0]       d4_en, d4_rd, d4_drop;

   // 3-port instance
   logic [2:0][31:0] d3_data;
   logic [2:0]       d3_empty, d3_ready;
   logic [2:0][1:0]  d3_sel;
   logic [2:0]       d3_en, d3_rd, d3_drop;

   int nvec = 0;
   int nerr = 0;

   xbar_sched #(.NPORTS(4), .DATA_W(32), .SCHED_PERIOD(P)) dut4 (
      .clk(clk), .rst_n(rst_n), .data_in(d4_data), .fifo_empty(d4_empty),
      .out_ready(d4_ready), .sel(d4_sel), .en(d4_en), .rdreq(d4_rd), .drop(d4_drop)
   );

   xbar_sched #(.NPORTS(3), .DATA_W(32), .SCHED_PERIOD(P)) dut3 (
      .clk(clk), .rst_n(rst_n), .data_in(d3_data), .fifo_empty(d3_empty),
      .out_ready(d3_ready), .sel(d3_sel), .en(d3_en), .rdreq(d3_rd), .drop(d3_drop)
   );

   function automatic logic [11:0] sel4(input int s3, input int s2, input int s1, input int s0);
      return {3'(s3), 3'(s2), 3'(s1), 3'(s0)};
   endfunction

   function automatic logic [5:0] sel3(input int s2, input int s1, input int s0);
      return {2'(s2), 2'(s1), 2'(s0)};
   endfunction

   function automatic logic any_out();
      return (|d4_sel) | (|d4_en) | (|d4_rd) | (|d4_drop) |
             (|d3_sel) | (|d3_en) | (|d3_rd) | (|d3_drop);
   endfunction

   // Advance one window; returns whether any output was nonzero on the two
   // non-decision cycles. Ends #1 after the decision edge.
   task automatic step_window(output logic stray);
      stray = 1'b0;
      for (int k = 0; k < P - 1; k++) begin
         @(posedge clk); #1;
         stray = stray | any_out();
      end
      @(posedge clk); #1;
   endtask

   task automatic idle_all();
      d4_data = '0; d4_empty = 4'hF; d4_ready = 4'hF;
      d3_data = '0; d3_empty = 3'h7; d3_ready = 3'h7;
   endtask

   task automatic test_reset();
      idle_all();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      nvec++;
      if (any_out() !== 1'b0) begin
         nerr++; $display("FAIL reset_outputs: got nonzero outputs, want all 0");
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_single_grant();
      logic stray;
      d4_data[0] = 32'h0000_0102; d4_empty = 4'b1110; d4_ready = 4'hF;
      step_window(stray);
      nvec++;
      if (stray !== 1'b0) begin nerr++; $display("FAIL single_early: stray output before 3rd edge"); end
      nvec++;
      if (d4_en !== 4'b0100) begin nerr++; $display("FAIL single_en: got %b want 0100", d4_en); end
      nvec++;
      if (d4_sel !== sel4(0, 1, 0, 0)) begin nerr++; $display("FAIL single_sel: got %h want %h", d4_sel, sel4(0, 1, 0, 0)); end
      nvec++;
      if (d4_rd !== 4'b0001 || d4_drop !== 4'b0000) begin
         nerr++; $display("FAIL single_rd: got rd=%b drop=%b want rd=0001 drop=0000", d4_rd, d4_drop);
      end
      d4_empty = 4'hF;
      @(posedge clk); #1;
      nvec++;
      if (any_out() !== 1'b0) begin nerr++; $display("FAIL single_pulse: outputs not cleared after one cycle"); end
      // realign to window boundary (one edge already consumed)
      repeat (P - 1) @(posedge clk);
      #1;
   endtask

   task automatic test_contention();
      logic stray;
      int   exp_sel[4];
`ifdef SCHED_RR_EN
      exp_sel = '{1, 2, 4, 1};
`else
      exp_sel = '{1, 1, 1, 1};
`endif
      d4_data[0] = 32'h11; d4_data[1] = 32'h21; d4_data[2] = 32'h0; d4_data[3] = 32'h31;
      d4_empty = 4'b0100; d4_ready = 4'hF;
      for (int w = 0; w < 4; w++) begin
         step_window(stray);
         nvec++;
         if (d4_sel !== sel4(0, 0, exp_sel[w], 0) || d4_en !== 4'b0010) begin
            nerr++; $display("FAIL contention_w%0d: sel=%h en=%b want sel=%h en=0010",
                             w, d4_sel, d4_en, sel4(0, 0, exp_sel[w], 0));
         end
         nvec++;
         if (d4_rd !== 4'(1 << (exp_sel[w] - 1))) begin
            nerr++; $display("FAIL contention_rd_w%0d: got %b want %b", w, d4_rd, 4'(1 << (exp_sel[w] - 1)));
         end
      end
   endtask

   task automatic test_blocking();
      logic stray;
      logic [3:0] exp_rd;
      int exp_s;
      // output 1 not ready: nothing granted, pointer stays put
      d4_ready = 4'b1101;
      step_window(stray);
      nvec++;
      if (d4_en !== 4'b0 || d4_rd !== 4'b0 || d4_sel !== '0) begin
         nerr++; $display("FAIL block_ready: en=%b rd=%b sel=%h want all 0", d4_en, d4_rd, d4_sel);
      end
      d4_ready = 4'hF;
`ifdef SCHED_RR_EN
      exp_s = 2; exp_rd = 4'b0010;
`else
      exp_s = 1; exp_rd = 4'b0001;
`endif
      step_window(stray);
      nvec++;
      if (d4_sel !== sel4(0, 0, exp_s, 0) || d4_rd !== exp_rd) begin
         nerr++; $display("FAIL block_resume: sel=%h rd=%b want sel=%h rd=%b",
                          d4_sel, d4_rd, sel4(0, 0, exp_s, 0), exp_rd);
      end
      // all FIFOs empty
      d4_empty = 4'hF;
      step_window(stray);
      nvec++;
      if (d4_rd !== 4'b0 || d4_en !== 4'b0) begin
         nerr++; $display("FAIL block_empty: rd=%b en=%b want 0000/0000", d4_rd, d4_en);
      end
      // nonempty but all-zero heads (dest 0 would otherwise be legal)
      d4_data = '0; d4_empty = 4'h0;
      step_window(stray);
      nvec++;
      if (d4_rd !== 4'b0 || d4_en !== 4'b0 || d4_drop !== 4'b0) begin
         nerr++; $display("FAIL block_zero: rd=%b en=%b drop=%b want 0", d4_rd, d4_en, d4_drop);
      end
   endtask

   task automatic test_parallel();
      logic stray;
      d4_data[0] = 32'h3; d4_data[1] = 32'h2; d4_data[2] = 32'h1; d4_data[3] = 32'h100;
      d4_empty = 4'h0; d4_ready = 4'hF;
      step_window(stray);
      nvec++;
      if (d4_en !== 4'hF || d4_rd !== 4'hF) begin
         nerr++; $display("FAIL parallel_en: en=%b rd=%b want 1111/1111", d4_en, d4_rd);
      end
      nvec++;
      if (d4_sel !== sel4(1, 2, 3, 4)) begin
         nerr++; $display("FAIL parallel_sel: got %h want %h", d4_sel, sel4(1, 2, 3, 4));
      end
      d4_data = '0; d4_empty = 4'hF;
   endtask

   task automatic test_bad_dest();
      logic stray;
      // input 2 -> dest 3 (out of range), input 0 -> dest 1
      d3_data[0] = 32'h5; d3_data[1] = 32'h0; d3_data[2] = 32'h3;
      d3_empty = 3'b010; d3_ready = 3'b111;
      step_window(stray);
      nvec++;
      if (d3_drop !== 3'b100 || d3_rd !== 3'b101) begin
         nerr++; $display("FAIL bad_mix_rd: drop=%b rd=%b want 100/101", d3_drop, d3_rd);
      end
      nvec++;
      if (d3_en !== 3'b010 || d3_sel !== sel3(0, 1, 0)) begin
         nerr++; $display("FAIL bad_mix_en: en=%b sel=%h want 010/%h", d3_en, d3_sel, sel3(0, 1, 0));
      end
      // drop is independent of output readiness
      d3_empty = 3'b011; d3_ready = 3'b000;
      step_window(stray);
      nvec++;
      if (d3_drop !== 3'b100 || d3_rd !== 3'b100 || d3_en !== 3'b000 || d3_sel !== '0) begin
         nerr++; $display("FAIL bad_only: drop=%b rd=%b en=%b want 100/100/000", d3_drop, d3_rd, d3_en);
      end
      d3_empty = 3'h7; d3_ready = 3'h7; d3_data = '0;
   endtask

   task automatic test_async_reset();
      logic stray;
      d4_data[0] = 32'h2; d4_empty = 4'b1110; d4_ready = 4'hF;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n = 1'b0;                 // one cycle before the decision edge
      @(posedge clk); #1;
      nvec++;
      if (any_out() !== 1'b0) begin nerr++; $display("FAIL areset_hold: grant survived reset"); end
      @(negedge clk);
      rst_n = 1'b1;
      step_window(stray);
      nvec++;
      if (stray !== 1'b0) begin nerr++; $display("FAIL areset_early: output before %0d edges after release", P); end
      nvec++;
      if (d4_en !== 4'b0100 || d4_rd !== 4'b0001 || d4_sel !== sel4(0, 1, 0, 0)) begin
         nerr++; $display("FAIL areset_grant: en=%b rd=%b sel=%h want 0100/0001/%h",
                          d4_en, d4_rd, d4_sel, sel4(0, 1, 0, 0));
      end
   endtask

   initial begin
      test_reset();
      test_single_grant();
      test_contention();
      test_blocking();
      test_parallel();
      test_bad_dest();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

   // Absolute guard so the run always ends.
   initial begin
      #20000;
      $display("FAIL timeout: bench did not finish, got stall want completion");
      $fatal(1);
   end

endmodule

// File: doc/xbar_sched.md
# xbar_sched

Parametrised crossbar scheduler for the switch datapath, successor to the fixed 3-port scheduler. Inspects the head word of every input FIFO, extracts the destination port field, arbitrates per output port among contending inputs (round-robin or fixed priority), and issues one-cycle FIFO read requests together with crossbar select/enable pulses. Sits between the input FIFOs and the crossbar mux / output RAM write enables.

## Interface
- NPORTS, 4, number of input and output ports (2..16)
- DATA_W, 32, FIFO head word width
- SCHED_PERIOD, 3, cycles per scheduling window (>=1); one decision per window
- SEL_W, $clog2(NPORTS+1), derived (localparam); select width
- DEST_W, $clog2(NPORTS), derived (localparam); destination field width, min 1
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- data_in  in  NPORTS x DATA_W  head word of input FIFO i (packed array)
- fifo_empty  in  NPORTS  input FIFO i empty
- out_ready  in  NPORTS  output port j can accept a packet this window
- sel  out  NPORTS x SEL_W  per output j: 0 = none, i+1 = input i
- en  out  NPORTS  output j granted this window
- rdreq  out  NPORTS  pop input FIFO i
- drop  out  NPORTS  input i head discarded (bad destination)

## Operation
- Phase counter counts 0..SCHED_PERIOD-1 and wraps. The decision edge is the rising edge at which phase == SCHED_PERIOD-1.
- Input i requests output d = data_in[i][DEST_W-1:0] when all three hold:
  - !fifo_empty[i]
  - data_in[i] != 0 (all-zero word = idle)
  - d < NPORTS
- Requests where d >= NPORTS do not arbitrate. They produce drop[i]=1 and rdreq[i]=1.
- Output j grants one input from its requests, only when out_ready[j]=1. On a grant:
  - en[j]=1, sel[j]=i+1
  - rdreq[i]=1
- An input has exactly one destination, so it is granted at most once per window. Outputs are granted independently.
- Round-robin: each output keeps a pointer ptr[j] (DEST_W bits).
  - Search starts at ptr[j]+1 mod NPORTS.
  - On a grant to input i, ptr[j] := i. With no grant, ptr[j] is unchanged.
- Non-decision edges: en, sel, rdreq and drop are all cleared to 0.
- Reset values:
  - en, sel, rdreq, drop = 0
  - phase = 0
  - ptr[j] = NPORTS-1, so input 0 has first priority.

## Timing
- All outputs are registered. They are valid for exactly one cycle, the cycle after the decision edge. They are 0 in every other cycle.
- Inputs are sampled only at the decision edge. Inputs in all other cycles are ignored.
- After rst_n deasserts, the first decision edge is the SCHED_PERIOD-th rising edge.
- Latency from sampling to rdreq is one edge. The FIFO pops on the next edge, so its new head is visible in the following window.
- SCHED_PERIOD=1 gives a decision every cycle. The FIFO must show its new head within one cycle (show-ahead).
- Reset asserted mid-window clears the phase and all outputs immediately (async). No partial grant survives.

## Configuration
- SCHED_RR_EN defined: round-robin per output as above.
- SCHED_RR_EN undefined: fixed priority, lowest input index wins. The ptr registers are not built.

## Structure
- Package xbar_pkg holds:
  - SEL_NONE = '0
  - a dest-field-extract function
  - typedef sel_t
- Sub-module rr_arbiter (parameter N) is instantiated once per output.
  - Inputs: req[N], ready, ptr.
  - Outputs: one-hot gnt, gnt_idx.
  - Under SCHED_RR_EN undefined it degrades to a priority encoder.

## Test plan
- Reset and single grant (NPORTS=4, PERIOD=3):
  - Stimulus: release reset; input 0 head 0x00000102 (dest 2), nonempty; out_ready=4'hF.
  - Response: in the cycle after the 3rd edge, en=4'b0100, sel[2]=1, rdreq=4'b0001. All outputs 0 the next cycle.
- Contention: inputs 0, 1 and 3 hold dest 1 across 4 windows.
  - With SCHED_RR_EN: sel[1] = 1, 2, 4, 1.
  - Without SCHED_RR_EN: sel[1] = 1 every window.
- Blocking conditions:
  - out_ready[1]=0 with requesters present gives en[1]=0 and no rdreq. ptr[1] is unchanged: after ready returns, the next grant is the one RR order expects.
  - fifo_empty set, or data_in all-zero, gives no rdreq.
- Parallel grants: four inputs with dests 3, 2, 1, 0 in the same window give en=4'hF, sel={1,2,3,4} (outputs 3..0), rdreq=4'hF.
- Bad destination (NPORTS=3): input 2 head dest 3 gives drop=3'b100 and rdreq=3'b100; en stays 0.
- Async reset mid-window: drop rst_n one cycle before the decision edge.
  - Response: outputs stay 0 and the phase restarts. The first grant lands SCHED_PERIOD edges after release.
